// File: rtl/wb_pkg.sv
// Shared Wishbone constants and arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    // Bus widths shared with if_wb.
    localparam int ADR_W = 16;
    localparam int DAT_W = 16;

    // Arbiter state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t GNT_A = 2'd1;
    localparam arb_state_t GNT_B = 2'd2;

    // Round-robin pointer: which master held the bus most recently.
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

endpackage

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// Latency: grant one cycle after cyc rises in IDLE; muxing is combinational from state.
// Backpressure: non-granted master always stalled; granted master stalled by slave or outstanding cap.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset,
    // requester A (dat_o = write data from A, dat_i = read data to A)
    input  logic             wbm_a_cyc,
    input  logic             wbm_a_stb,
    input  logic             wbm_a_we,
    input  logic [ADR_W-1:0] wbm_a_adr,
    input  logic [DAT_W-1:0] wbm_a_dat_o,
    output logic [DAT_W-1:0] wbm_a_dat_i,
    output logic             wbm_a_ack,
    output logic             wbm_a_stall,
    // requester B
    input  logic             wbm_b_cyc,
    input  logic             wbm_b_stb,
    input  logic             wbm_b_we,
    input  logic [ADR_W-1:0] wbm_b_adr,
    input  logic [DAT_W-1:0] wbm_b_dat_o,
    output logic [DAT_W-1:0] wbm_b_dat_i,
    output logic             wbm_b_ack,
    output logic             wbm_b_stall,
    // shared slave (names from the slave's viewpoint: dat_i = write data, dat_o = read data)
    output logic             wbs_cyc,
    output logic             wbs_stb,
    output logic             wbs_we,
    output logic [ADR_W-1:0] wbs_adr,
    output logic [DAT_W-1:0] wbs_dat_i,
    input  logic [DAT_W-1:0] wbs_dat_o,
    input  logic             wbs_ack,
    input  logic             wbs_stall,
    // status
    output logic             busy,
    output logic [1:0]       gnt,
    output logic             protocol_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            last;
    logic            last_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            cap;
    logic            accept;
    logic            release_bus;
    logic            err_set;

    // Registered count, so an ack in the capped cycle only frees a slot next cycle.
    assign cap    = (cnt == CW'(MAX_OUTSTANDING));
    assign accept = wbs_stb & ~wbs_stall;

    assign busy = (state != IDLE);
    assign gnt  = {state == GNT_B, state == GNT_A};

    // Bus mux: steer the granted master to the slave, hold everyone else off.
    always_comb begin
        wbs_cyc     = 1'b0;
        wbs_stb     = 1'b0;
        wbs_we      = 1'b0;
        wbs_adr     = '0;
        wbs_dat_i   = '0;
        wbm_a_ack   = 1'b0;
        wbm_a_stall = 1'b1;
        wbm_b_ack   = 1'b0;
        wbm_b_stall = 1'b1;
        wbm_a_dat_i = wbs_dat_o;
        wbm_b_dat_i = wbs_dat_o;
        case (state)
            GNT_A: begin
                wbs_cyc     = wbm_a_cyc;
                wbs_stb     = wbm_a_stb & ~cap;
                wbs_we      = wbm_a_we;
                wbs_adr     = wbm_a_adr;
                wbs_dat_i   = wbm_a_dat_o;
                wbm_a_ack   = wbs_ack;
                wbm_a_stall = wbs_stall | cap;
            end
            GNT_B: begin
                wbs_cyc     = wbm_b_cyc;
                wbs_stb     = wbm_b_stb & ~cap;
                wbs_we      = wbm_b_we;
                wbs_adr     = wbm_b_adr;
                wbs_dat_i   = wbm_b_dat_o;
                wbm_b_ack   = wbs_ack;
                wbm_b_stall = wbs_stall | cap;
            end
            default: ;
        endcase
    end

    // Next-state, round-robin pointer and outstanding-count logic.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        release_bus = 1'b0;
        case (state)
            IDLE: begin
                if (wbm_a_cyc && wbm_b_cyc)
                    state_nxt = (last == LAST_B) ? GNT_A : GNT_B;
                else if (wbm_a_cyc)
                    state_nxt = GNT_A;
                else if (wbm_b_cyc)
                    state_nxt = GNT_B;
            end
            GNT_A: begin
                if (!wbm_a_cyc) begin
                    release_bus = 1'b1;
                    last_nxt    = LAST_A;
                    state_nxt   = wbm_b_cyc ? GNT_B : IDLE;
                end
            end
            GNT_B: begin
                if (!wbm_b_cyc) begin
                    release_bus = 1'b1;
                    last_nxt    = LAST_B;
                    state_nxt   = wbm_a_cyc ? GNT_A : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Release always wins: leftover transfers are abandoned and flagged.
        cnt_nxt = cnt;
        if (release_bus)
            cnt_nxt = '0;
        else if (accept && !wbs_ack)
            cnt_nxt = cnt + CW'(1);
        else if (!accept && wbs_ack && (cnt != '0))
            cnt_nxt = cnt - CW'(1);

        err_set = (release_bus && (cnt != '0))
                | (wbs_ack && (cnt == '0) && !accept)
                | (wbs_ack && (state == IDLE));
    end

    // State, pointer, counter and sticky error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last         <= LAST_B;
            cnt          <= '0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            cnt          <= cnt_nxt;
            protocol_err <= protocol_err | err_set;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, corner-case sequences, random vs reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: slave stall/ack driven by the bench.
module tb_wb_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cyc, a_stb, a_we;
    logic [15:0] a_adr, a_wdat, a_rdat;
    logic        a_ack, a_stall;
    logic        b_cyc, b_stb, b_we;
    logic [15:0] b_adr, b_wdat, b_rdat;
    logic        b_ack, b_stall;
    logic        s_cyc, s_stb, s_we;
    logic [15:0] s_adr, s_wdat, s_rdat;
    logic        s_ack, s_stall;
    logic        busy;
    logic [1:0]  gnt;
    logic        perr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(rst),
        .wbm_a_cyc(a_cyc), .wbm_a_stb(a_stb), .wbm_a_we(a_we), .wbm_a_adr(a_adr),
        .wbm_a_dat_o(a_wdat), .wbm_a_dat_i(a_rdat), .wbm_a_ack(a_ack), .wbm_a_stall(a_stall),
        .wbm_b_cyc(b_cyc), .wbm_b_stb(b_stb), .wbm_b_we(b_we), .wbm_b_adr(b_adr),
        .wbm_b_dat_o(b_wdat), .wbm_b_dat_i(b_rdat), .wbm_b_ack(b_ack), .wbm_b_stall(b_stall),
        .wbs_cyc(s_cyc), .wbs_stb(s_stb), .wbs_we(s_we), .wbs_adr(s_adr),
        .wbs_dat_i(s_wdat), .wbs_dat_o(s_rdat), .wbs_ack(s_ack), .wbs_stall(s_stall),
        .busy(busy), .gnt(gnt), .protocol_err(perr)
    );

    // inputs {rst,a_cyc,a_stb,b_cyc,b_stb,s_stall,s_ack}
    // expect {busy,gnt[1:0],err,s_cyc,s_stb,a_stall,a_ack,b_stall,b_ack}
    typedef struct {
        logic [6:0]  in;
        logic [9:0]  ex;
        logic [15:0] adr;
    } vec_t;

    localparam logic [9:0] EX_IDLE = 10'b0_00_0_0_0_1_0_1_0;

    vec_t vecs[19];

    // Model state for the random phase: owner 0 none / 1 A / 2 B.
    int   m_owner, m_last, m_cnt;
    logic m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [6:0] in, input logic [9:0] ex, input logic [15:0] adr);
        vec_t v;
        v.in = in; v.ex = ex; v.adr = adr;
        return v;
    endfunction

    function automatic logic [9:0] ctl_now();
        return {busy, gnt, perr, s_cyc, s_stb, a_stall, a_ack, b_stall, b_ack};
    endfunction

    task automatic quiet();
        a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0; s_stall = 0; s_ack = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        quiet(); rst = 1;
        next_cycle(); next_cycle();
        rst = 0;
    endtask

    initial begin
        int acc_cyc[$];
        int ack_at[$];
        int sent, maxcnt;
        logic [1:0] st_seen;

        vecs[0]  = mk(7'b1_00_00_00, EX_IDLE, 16'h0000);
        vecs[1]  = mk(7'b0_11_00_00, EX_IDLE, 16'h0000);
        vecs[2]  = mk(7'b0_11_00_00, 10'b1_01_0_1_1_0_0_1_0, 16'h0010);
        vecs[3]  = mk(7'b0_10_00_01, 10'b1_01_0_1_0_0_1_1_0, 16'h0010);
        vecs[4]  = mk(7'b0_00_00_00, 10'b1_01_0_0_0_0_0_1_0, 16'h0010);
        vecs[5]  = mk(7'b0_00_00_00, EX_IDLE, 16'h0000);
        vecs[6]  = mk(7'b1_00_00_00, EX_IDLE, 16'h0000);
        vecs[7]  = mk(7'b0_11_11_00, EX_IDLE, 16'h0000);
        vecs[8]  = mk(7'b0_11_11_00, 10'b1_01_0_1_1_0_0_1_0, 16'h0010);
        vecs[9]  = mk(7'b0_10_11_01, 10'b1_01_0_1_0_0_1_1_0, 16'h0010);
        vecs[10] = mk(7'b0_00_11_00, 10'b1_01_0_0_0_0_0_1_0, 16'h0010);
        vecs[11] = mk(7'b0_00_11_00, 10'b1_10_0_1_1_1_0_0_0, 16'h0020);
        vecs[12] = mk(7'b0_00_10_01, 10'b1_10_0_1_0_1_0_0_1, 16'h0020);
        vecs[13] = mk(7'b0_00_00_00, 10'b1_10_0_0_0_1_0_0_0, 16'h0020);
        vecs[14] = mk(7'b0_11_11_00, EX_IDLE, 16'h0000);
        vecs[15] = mk(7'b0_11_11_00, 10'b1_01_0_1_1_0_0_1_0, 16'h0010);
        vecs[16] = mk(7'b0_11_11_10, 10'b1_01_0_1_1_1_0_1_0, 16'h0010);
        vecs[17] = mk(7'b0_10_11_01, 10'b1_01_0_1_0_0_1_1_0, 16'h0010);
        vecs[18] = mk(7'b0_00_11_00, 10'b1_01_0_0_0_0_0_1_0, 16'h0010);

        a_we = 0; b_we = 1; a_adr = 16'h0010; b_adr = 16'h0020;
        a_wdat = 16'h1111; b_wdat = 16'h2222; s_rdat = 16'hbeef;
        quiet(); rst = 1;
        next_cycle(); next_cycle();

        // ---------------- vector table ----------------
        for (int i = 0; i < 19; i++) begin
            {rst, a_cyc, a_stb, b_cyc, b_stb, s_stall, s_ack} = vecs[i].in;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), 64'(ctl_now()), 64'(vecs[i].ex));
            if (vecs[i].ex[8:7] != 2'b00)
                chk($sformatf("vec%0d_adr", i), 64'(s_adr), 64'(vecs[i].adr));
            next_cycle();
        end

        // ---------------- cap: MAXO=2, slave acks 3 cycles late ----------------
        do_reset();
        sent = 0; maxcnt = 0; st_seen = 2'b00;
        for (int c = 0; c < 12; c++) begin
            a_cyc = (c < 10);
            a_stb = a_cyc && (sent < 4);
            s_ack = (ack_at.size() > 0) && (ack_at[0] == c);
            @(negedge clk);
            if (int'(dut.cnt) > maxcnt) maxcnt = int'(dut.cnt);
            if (c == 3) st_seen[0] = a_stall;
            if (c == 4) st_seen[1] = a_stall;
            if (s_stb && !s_stall) begin
                acc_cyc.push_back(c);
                ack_at.push_back(c + 3);
                sent++;
            end
            if (s_ack) void'(ack_at.pop_front());
            next_cycle();
        end
        chk("cap_n_accepts", 64'(acc_cyc.size()), 64'd4);
        if (acc_cyc.size() == 4) begin
            chk("cap_acc0", 64'(acc_cyc[0]), 64'd1);
            chk("cap_acc1", 64'(acc_cyc[1]), 64'd2);
            chk("cap_acc2", 64'(acc_cyc[2]), 64'd5);
            chk("cap_acc3", 64'(acc_cyc[3]), 64'd6);
        end
        chk("cap_stall_seen", 64'(st_seen), 64'b11);
        chk("cap_max_cnt", 64'(maxcnt), 64'd2);
        chk("cap_err", 64'(perr), 64'd0);

        // ---------------- simultaneous accept and ack ----------------
        do_reset();
        for (int c = 0; c < 9; c++) begin
            a_cyc = (c <= 6);
            a_stb = (c <= 5);
            s_ack = (c >= 2 && c <= 6);
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                chk($sformatf("sim_cnt_c%0d", c), 64'(dut.cnt), 64'd1);
                chk($sformatf("sim_ack_c%0d", c), 64'(a_ack), 64'd1);
            end
            next_cycle();
        end
        chk("sim_err", 64'(perr), 64'd0);

        // ---------------- ack in IDLE, then reset mid-cycle with cnt=2 ----------------
        do_reset();
        s_ack = 1;
        @(negedge clk);
        chk("idle_ack_fwd", 64'({a_ack, b_ack}), 64'b00);
        next_cycle();
        s_ack = 0; a_cyc = 1; a_stb = 1;
        @(negedge clk);
        chk("idle_ack_err", 64'(perr), 64'd1);
        next_cycle(); next_cycle(); next_cycle();
        b_cyc = 1; b_stb = 1; rst = 1;
        @(negedge clk);
        chk("pre_reset_cnt", 64'(dut.cnt), 64'd2);
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("post_reset", 64'({busy, gnt, s_cyc, s_stb, perr}), 64'b0_00_0_0_0);
        next_cycle();
        @(negedge clk);
        chk("post_reset_tie", 64'(gnt), 64'b01);
        next_cycle();

        // ---------------- release with cnt=1 ----------------
        do_reset();
        a_cyc = 1; a_stb = 1;
        next_cycle();
        next_cycle();                       // accepted, cnt=1
        a_cyc = 0; a_stb = 0;
        @(negedge clk);
        chk("drop_err_before", 64'(perr), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("drop_state", 64'({perr, busy, gnt}), 64'b1_0_00);
        chk("drop_cnt", 64'(dut.cnt), 64'd0);
        next_cycle();

        // ---------------- random vs reference model ----------------
        m_owner = 0; m_last = 2; m_cnt = 0; m_err = 0;
        rst = 1; quiet();
        for (int c = 0; c < 3000; c++) begin
            logic        cap, e_stb, acc, own_cyc, oth_cyc;
            logic [9:0]  e_ctl;
            logic [48:0] e_dat, a_dat;
            if (c > 0) begin
                rst = ($urandom_range(0, 199) == 0);
                if (a_cyc) a_cyc = (m_owner == 1 && m_cnt != 0) ? ($urandom_range(0, 31) != 0)
                                                               : ($urandom_range(0, 7) != 0);
                else       a_cyc = ($urandom_range(0, 3) == 0);
                if (b_cyc) b_cyc = (m_owner == 2 && m_cnt != 0) ? ($urandom_range(0, 31) != 0)
                                                               : ($urandom_range(0, 7) != 0);
                else       b_cyc = ($urandom_range(0, 3) == 0);
                a_stb   = a_cyc && ($urandom_range(0, 3) != 0);
                b_stb   = b_cyc && ($urandom_range(0, 3) != 0);
                s_stall = ($urandom_range(0, 3) == 0);
                s_ack   = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            end
            a_we = 1'($urandom); b_we = 1'($urandom);
            a_adr = 16'($urandom); b_adr = 16'($urandom);
            a_wdat = 16'($urandom); b_wdat = 16'($urandom); s_rdat = 16'($urandom);
            @(negedge clk);

            cap   = (m_owner != 0) && (m_cnt == MAXO);
            e_stb = (m_owner == 1) ? (a_stb && !cap) : (m_owner == 2) ? (b_stb && !cap) : 1'b0;
            e_ctl = {m_owner != 0, m_owner == 2, m_owner == 1, m_err,
                     (m_owner == 1) ? a_cyc : (m_owner == 2) ? b_cyc : 1'b0,
                     e_stb,
                     (m_owner == 1) ? (s_stall || cap) : 1'b1,
                     (m_owner == 1) ? s_ack : 1'b0,
                     (m_owner == 2) ? (s_stall || cap) : 1'b1,
                     (m_owner == 2) ? s_ack : 1'b0};
            if (c > 0) begin
                chk($sformatf("rand%0d_ctl", c), 64'(ctl_now()), 64'(e_ctl));
                chk($sformatf("rand%0d_rdat", c), 64'({a_rdat, b_rdat}), 64'({s_rdat, s_rdat}));
                if (m_owner != 0) begin
                    e_dat = (m_owner == 1) ? {a_we, a_adr, a_wdat, 16'h0} : {b_we, b_adr, b_wdat, 16'h0};
                    a_dat = {s_we, s_adr, s_wdat, 16'h0};
                    chk($sformatf("rand%0d_fwd", c), 64'(a_dat), 64'(e_dat));
                end
            end

            // advance the model across the coming edge
            if (rst) begin
                m_owner = 0; m_last = 2; m_cnt = 0; m_err = 0;
            end else begin
                acc = e_stb && !s_stall;
                if (s_ack && (m_owner == 0 || (m_cnt == 0 && !acc))) m_err = 1;
                if (m_owner == 0) begin
                    if (a_cyc && b_cyc) m_owner = (m_last == 2) ? 1 : 2;
                    else if (a_cyc)     m_owner = 1;
                    else if (b_cyc)     m_owner = 2;
                end else begin
                    own_cyc = (m_owner == 1) ? a_cyc : b_cyc;
                    oth_cyc = (m_owner == 1) ? b_cyc : a_cyc;
                    if (!own_cyc) begin
                        if (m_cnt != 0) m_err = 1;
                        m_last  = m_owner;
                        m_owner = oth_cyc ? 3 - m_owner : 0;
                        m_cnt   = 0;
                    end else begin
                        m_cnt = m_cnt + int'(acc) - int'(s_ack);
                        if (m_cnt < 0) m_cnt = 0;
                    end
                end
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master round-robin arbiter sharing one pipelined Wishbone slave. Typical use: J1 data bus plus a second bus master (DMA, debug loader) sharing the data RAM or an I/O slave. Grant is held for a whole bus cycle (`cyc` high), and handover is round-robin. The block tracks outstanding pipelined transfers, caps them at a configurable limit, and flags protocol violations.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unacknowledged strobes per cycle; range 1..15.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `wbm_a` if_wb.slave: requester A, 16-bit address and data, pipelined (`stall`).
- `wbm_b` if_wb.slave: requester B, same format.
- `wbs` if_wb.master: the shared slave.
- `busy` out 1: a grant is active (state ≠ IDLE).
- `gnt` out 2: one-hot current grant (bit0 = A, bit1 = B).
- `protocol_err` out 1: sticky; cleared only by reset.

## Operation
- States are IDLE, GNT_A and GNT_B. The state register, the priority pointer `last` and the outstanding counter `cnt` are registered. All bus muxing is combinational from the state.
- IDLE:
  - Both masters see `stall=1` and `ack=0`; `wbs.cyc=0` and `wbs.stb=0`.
  - If only one master has `cyc=1`, go to its grant state.
  - If both do, grant the master that is not `last`.
  - At reset `last=B`, so A wins the first tie.
- GNT_x, master x to slave:
  - Forward `adr`, `dat_o` and `we` unchanged.
  - `wbs.cyc = x.cyc`.
  - `wbs.stb = x.stb & ~cap`, where `cap = (cnt == MAX_OUTSTANDING)`.
- GNT_x, slave to master x:
  - `x.ack = wbs.ack`.
  - `x.stall = wbs.stall | cap`.
  - `x.dat_i = wbs.dat_o`.
- The non-granted master always sees `stall=1`, `ack=0` and `dat_i = wbs.dat_o`. It is never forwarded to the slave.
- Counter:
  - +1 on an accepted strobe (`wbs.stb & ~wbs.stall`).
  - −1 on `wbs.ack`.
  - Both in the same cycle leave it unchanged.
  - Width is `$clog2(MAX_OUTSTANDING+1)`.
- Release: in GNT_x, when `x.cyc=0`, set `last=x`.
  - If the other master has `cyc=1`, go directly to its grant state (no IDLE bubble).
  - Otherwise go to IDLE.
- Release is taken even if `cnt≠0`. In that case, set `protocol_err` and force `cnt` to 0 on the transition.
- `protocol_err` also sets on:
  - `wbs.ack` while `cnt==0` with no accept in the same cycle;
  - `wbs.ack` in IDLE.
- Stray acks are never forwarded to either master.
- Reset at any time, including mid-cycle with outstanding transfers:
  - next state IDLE, `cnt=0`, `last=B`, `protocol_err=0`;
  - `wbs.cyc` and `wbs.stb` are low from the next cycle.

## Timing
- Reset values: `busy=0`, `gnt=2'b00`, `protocol_err=0`, `wbs.cyc=0`, `wbs.stb=0`; both masters see `stall=1` and `ack=0`.
- Grant latency: a master raises `cyc`/`stb` at cycle n from IDLE. It is granted at n+1, when its `stb` reaches the slave and `stall` reflects the slave. It is stalled during cycle n.
- Handover: the granted master drops `cyc` at cycle m while the other is waiting. The other's `stb` reaches the slave at m+1.
- Throughput: one accepted strobe per cycle while `cnt<MAX_OUTSTANDING` and the slave does not stall.
- At `cnt==MAX_OUTSTANDING`:
  - a same-cycle ack does not lift `cap` (registered count);
  - the next strobe is accepted in the cycle after the ack.
- No combinational path from master inputs to `gnt` or `busy`.

## Structure
- Shared package `wb_pkg`: state enum `arb_state_t` (IDLE, GNT_A, GNT_B) and the 16-bit address/data width constants already used by `if_wb`.
- No sub-module; a single module around one FSM plus the counter. An N-master generalisation is explicitly out of scope.

## Test plan
- Single request: A issues `cyc`/`stb` to adr 0x0010 at n → `wbs.stb` at n+1, `gnt=01`, ack returned to A only; B `stall=1` throughout.
- Tie: A and B both request from reset → A granted first. A drops `cyc` at m → B's `stb` on the slave at m+1, `gnt=10`. Next tie → A.
- Pipelining cap (`MAX_OUTSTANDING=2`, slave acks 3 cycles late): A streams 4 strobes → after 2 accepts A sees `stall=1`; third accepted the cycle after the first ack; `cnt` never exceeds 2.
- Simultaneous accept and ack: `cnt` stays at 1 over 5 back-to-back single-latency transfers; `protocol_err=0`.
- Violations: slave acks in IDLE → `protocol_err=1`, no master sees `ack`. Separately, A drops `cyc` with `cnt=1` → `protocol_err=1`, `cnt=0`, next state IDLE.
- Reset mid-cycle with `cnt=2` → next cycle: state IDLE, `wbs.cyc=0`, `gnt=00`, `protocol_err=0`; a following tie grants A.
